// File: rtl/mdio_phy_responder_pkg.sv
// Shared MDIO management definitions: opcodes, responder FSM states, defaults.
package mdio_phy_responder_pkg;

  localparam int MdioPreambleLen = 32;

  // Clause 22 OP field encodings
  typedef enum logic [1:0] {
    MDIO_OP_WRITE = 2'b01,
    MDIO_OP_READ  = 2'b10
  } mdio_op_e;

  // Responder frame walk, one field per state
  typedef enum logic [2:0] {
    MDIO_HUNT  = 3'd0,
    MDIO_ST    = 3'd1,
    MDIO_OP    = 3'd2,
    MDIO_PHYAD = 3'd3,
    MDIO_REGAD = 3'd4,
    MDIO_TA    = 3'd5,
    MDIO_DATA  = 3'd6
  } mdio_state_e;

endpackage

// File: rtl/mdio_phy_responder_sync.sv
// Plain flop-chain synchronizer; MDC and MDIO use identical instances so they stay aligned.
module mdio_phy_responder_sync #(
  parameter int Stages = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [Stages-1:0] ff;

  // shift the asynchronous input through the chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= (ff << 1) | Stages'(d);
  end

  assign q = ff[Stages-1];

endmodule

// File: rtl/mdio_phy_responder.sv
// PHY-side Clause 22 MDIO responder: oversamples MDC/MDIO, decodes frames,
// issues register strobes and drives read data back on MDIO.
module mdio_phy_responder
  import mdio_phy_responder_pkg::*;
#(
  parameter int SyncStages  = 3,
  parameter int PreambleLen = MdioPreambleLen
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mdc_i,
  input  logic        md_i,
  output logic        md_o,
  output logic        md_oe_o,
  input  logic [4:0]  phy_addr_i,
  output logic        reg_req_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_addr_o,
  output logic [15:0] reg_wdata_o,
  input  logic [15:0] reg_rdata_i,
  output logic        frame_err_o
);

  // counter also walks 5-bit and 16-bit fields, so never narrower than 5
  localparam int CntW = ($clog2(PreambleLen + 1) > 5) ? $clog2(PreambleLen + 1) : 5;
  localparam logic [CntW-1:0] PreMax  = CntW'(PreambleLen);
  localparam logic [CntW-1:0] One     = CntW'(1);
  localparam logic [CntW-1:0] Last5   = CntW'(4);
  localparam logic [CntW-1:0] Last16  = CntW'(15);

  logic mdc_s, md_s, mdc_q, rise;

  mdio_phy_responder_sync #(.Stages(SyncStages)) u_sync_mdc (
    .clk(clk_i), .rst(rst_i), .d(mdc_i), .q(mdc_s)
  );
  mdio_phy_responder_sync #(.Stages(SyncStages)) u_sync_md (
    .clk(clk_i), .rst(rst_i), .d(md_i), .q(md_s)
  );

  // previous synchronized MDC for rising-edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mdc_q <= 1'b0;
    else       mdc_q <= mdc_s;
  end

  assign rise = mdc_s & ~mdc_q;

  mdio_state_e     state;
  logic [CntW-1:0] cnt;
  logic            op_hi;
  logic            rd;
  logic            sel;
  logic            rd_cap;
  logic [4:0]      phyad;
  logic [4:0]      regad;
  logic [15:0]     sh;
  mdio_op_e        op;

  assign op = mdio_op_e'({op_hi, md_s});

  // frame FSM: bit actions on MDC rise; strobes/pulses are single-cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= MDIO_HUNT;
      cnt         <= '0;
      op_hi       <= 1'b0;
      rd          <= 1'b0;
      sel         <= 1'b0;
      rd_cap      <= 1'b0;
      phyad       <= '0;
      regad       <= '0;
      sh          <= '0;
      md_o        <= 1'b0;
      md_oe_o     <= 1'b0;
      reg_req_o   <= 1'b0;
      reg_we_o    <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      frame_err_o <= 1'b0;
    end else begin
      reg_req_o   <= 1'b0;
      frame_err_o <= 1'b0;
      // register file answers one cycle after the read strobe; capture once
      rd_cap      <= reg_req_o & ~reg_we_o;
      if (rd_cap) sh <= reg_rdata_i;

      if (rise) begin
        case (state)
          MDIO_HUNT: begin
            if (md_s) begin
              if (cnt != PreMax) cnt <= cnt + One;
            end else if (cnt == PreMax) begin
              state <= MDIO_ST;
              cnt   <= '0;
            end else begin
              cnt <= '0;
            end
          end
          MDIO_ST: begin
            if (md_s) begin
              state <= MDIO_OP;
            end else begin
              frame_err_o <= 1'b1;
              state       <= MDIO_HUNT;
            end
            cnt <= '0;
          end
          MDIO_OP: begin
            if (cnt == '0) begin
              op_hi <= md_s;
              cnt   <= One;
            end else begin
              cnt <= '0;
              case (op)
                MDIO_OP_READ: begin
                  rd    <= 1'b1;
                  state <= MDIO_PHYAD;
                end
                MDIO_OP_WRITE: begin
                  rd    <= 1'b0;
                  state <= MDIO_PHYAD;
                end
                default: begin
                  frame_err_o <= 1'b1;
                  state       <= MDIO_HUNT;
                end
              endcase
            end
          end
          MDIO_PHYAD: begin
            phyad <= {phyad[3:0], md_s};
            if (cnt == Last5) begin
              cnt   <= '0;
              state <= MDIO_REGAD;
            end else begin
              cnt <= cnt + One;
            end
          end
          MDIO_REGAD: begin
            regad <= {regad[3:0], md_s};
            if (cnt == Last5) begin
              cnt   <= '0;
              state <= MDIO_TA;
              sel   <= (phyad == phy_addr_i);
              if (phyad == phy_addr_i) begin
                reg_addr_o <= {regad[3:0], md_s};
                if (rd) begin
                  reg_req_o <= 1'b1;
                  reg_we_o  <= 1'b0;
                end
              end
            end else begin
              cnt <= cnt + One;
            end
          end
          MDIO_TA: begin
            if (cnt == '0) begin
              cnt <= One;
              // TA bit 1 stays released; take the line with the TA zero
              if (sel && rd) begin
                md_oe_o <= 1'b1;
                md_o    <= 1'b0;
              end
            end else begin
              cnt   <= '0;
              state <= MDIO_DATA;
              if (sel && rd) begin
                md_o <= sh[15];
                sh   <= {sh[14:0], 1'b0};
              end
            end
          end
          MDIO_DATA: begin
            if (cnt == Last16) begin
              cnt     <= '0;
              state   <= MDIO_HUNT;
              md_oe_o <= 1'b0;
              md_o    <= 1'b0;
              if (sel && !rd) begin
                reg_req_o   <= 1'b1;
                reg_we_o    <= 1'b1;
                reg_wdata_o <= {sh[14:0], md_s};
              end
            end else begin
              cnt <= cnt + One;
              if (rd) begin
                if (sel) md_o <= sh[15];
                sh <= {sh[14:0], 1'b0};
              end else begin
                sh <= {sh[14:0], md_s};
              end
            end
          end
          default: begin
            state <= MDIO_HUNT;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
